// File: rtl/axis_frame_builder_if.sv
// AXI-Stream bundle. The Source side also drives clk/reset so that a
// downstream sink (e.g. the AXIS FIFO) can be clocked from the stream itself.
interface axis_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic                        clk;
    logic                        reset;
    logic [DATA_WIDTH-1:0]       tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;
    logic [(DATA_WIDTH+7)/8-1:0] tkeep;
    logic [ID_WIDTH-1:0]         tid;
    logic [DEST_WIDTH-1:0]       tdest;
    logic                        tuser;

    modport Source (
        output clk, reset, tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
        input  tready
    );

    modport Sink (
        input  clk, reset, tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_builder.sv
// Frames a non-backpressurable byte strobe into AXI-Stream frames, closing on
// an idle timeout or a maximum length; tuser on the last beat flags lost bytes.
module axis_frame_builder #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 64,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    axis_interface.Source         source,
    output logic                  overflow_o,
    output logic                  busy_o
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  tvalid_q, tvalid_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  err_q, err_d;
    logic                  overflow_q, overflow_d;

    logic out_free;
    logic len_full;
    logic idle_done;

    assign out_free  = !tvalid_q || source.tready;
    assign len_full  = (len_q == LEN_W'(MAX_LEN));
    assign idle_done = (idle_q == IDLE_W'(TIMEOUT));

    always_comb begin
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tvalid_d     = tvalid_q;
        len_d        = len_q;
        idle_d       = idle_q;
        err_d        = err_q;
        overflow_d   = 1'b0;

        if (tvalid_q && source.tready) begin
            tvalid_d = 1'b0;
        end

        if (pend_valid_q && len_full && out_free) begin
            // Max-length flush; a same-cycle strobe opens the next frame.
            tdata_d  = pend_data_q;
            tlast_d  = 1'b1;
            tuser_d  = err_q;
            tvalid_d = 1'b1;
            err_d    = 1'b0;
            if (in_valid_i) begin
                pend_data_d  = in_data_i;
                pend_valid_d = 1'b1;
                len_d        = LEN_W'(1);
                idle_d       = '0;
            end else begin
                pend_valid_d = 1'b0;
                len_d        = '0;
                idle_d       = '0;
            end
        end else if (in_valid_i && pend_valid_q) begin
            if (out_free) begin
                tdata_d     = pend_data_q;
                tlast_d     = 1'b0;
                tuser_d     = 1'b0;
                tvalid_d    = 1'b1;
                pend_data_d = in_data_i;
                len_d       = len_q + LEN_W'(1);
                idle_d      = '0;
            end else begin
                err_d      = 1'b1;
                overflow_d = 1'b1;
            end
        end else if (in_valid_i) begin
            pend_data_d  = in_data_i;
            pend_valid_d = 1'b1;
            len_d        = LEN_W'(1);
            idle_d       = '0;
        end else if (pend_valid_q && idle_done && out_free) begin
            tdata_d      = pend_data_q;
            tlast_d      = 1'b1;
            tuser_d      = err_q;
            tvalid_d     = 1'b1;
            err_d        = 1'b0;
            pend_valid_d = 1'b0;
            len_d        = '0;
            idle_d       = '0;
        end else if (pend_valid_q) begin
            if (!idle_done) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            len_q        <= '0;
            idle_q       <= '0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            len_q        <= len_d;
            idle_q       <= idle_d;
            err_q        <= err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign source.clk    = clk_i;
    assign source.reset  = reset_i;
    assign source.tdata  = tdata_q;
    assign source.tvalid = tvalid_q;
    assign source.tlast  = tlast_q;
    assign source.tuser  = tuser_q;
    assign source.tkeep  = '1;
    assign source.tid    = '0;
    assign source.tdest  = '0;

    assign overflow_o = overflow_q;
    assign busy_o     = pend_valid_q || tvalid_q;
endmodule

// File: tb/tb_axis_frame_builder.sv
// Self-checking bench for axis_frame_builder: directed scenarios plus a
// randomized strobe pattern scored against a frame-level reference model.
module tb_axis_frame_builder;
    localparam int DW = 8;
    localparam int ML = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic        last;
        logic        user;
        logic [31:0] cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       overflow;
    logic       busy;

    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    ovf_cnt = 0;
    beat_t q[$];
    beat_t mon_b;

    axis_interface #(.DATA_WIDTH(DW)) bus ();

    axis_frame_builder #(
        .DATA_WIDTH(DW),
        .MAX_LEN   (ML),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .in_data_i (in_data),
        .in_valid_i(in_valid),
        .source    (bus),
        .overflow_o(overflow),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.tvalid && bus.tready) begin
            mon_b.d    = bus.tdata;
            mon_b.last = bus.tlast;
            mon_b.user = bus.tuser;
            mon_b.cyc  = cyc;
            q.push_back(mon_b);
        end
        if (overflow) ovf_cnt = ovf_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one byte in the current cycle; returns that cycle number.
    task automatic strobe(input logic [7:0] d, output int c);
        c        = cyc;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom_range(0, 255);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus.tvalid); end
        checks++; if (bus.tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", bus.tdata); end
        checks++; if (bus.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", bus.tlast); end
        checks++; if (bus.tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", bus.tuser); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bus.tkeep !== 1'b1 || bus.tid !== 1'b0 || bus.tdest !== 1'b0) begin
            errors++; $display("FAIL reset_ties got keep=%b id=%b dest=%b want 1/0/0", bus.tkeep, bus.tid, bus.tdest);
        end
        reset = 1'b0;
        q.delete();
        repeat (TO + 4) tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL reset_no_beat got %0d beats want 0", q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic [9:0] exp [3];
        int c;
        exp[0] = {8'hA1, 1'b0, 1'b0};
        exp[1] = {8'hA2, 1'b0, 1'b0};
        exp[2] = {8'hA3, 1'b1, 1'b0};
        bus.tready = 1'b1;
        q.delete();
        strobe(8'hA1, c);
        strobe(8'hA2, c);
        strobe(8'hA3, c);
        wait_beats(3, TO + 20);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q.size()) begin
                errors++; $display("FAIL timeout_beat%0d missing got %0d beats want 3", i, q.size());
            end else if ({q[i].d, q[i].last, q[i].user} !== exp[i]) begin
                errors++; $display("FAIL timeout_beat%0d got %h/%b/%b want %h/%b/%b", i, q[i].d, q[i].last, q[i].user, exp[i][9:2], exp[i][1], exp[i][0]);
            end
        end
        checks++;
        if (q.size() < 3 || q[2].cyc != 32'(c + TO + 2)) begin
            errors++; $display("FAIL timeout_latency got cycle %0d want %0d", (q.size() < 3) ? -1 : int'(q[2].cyc), c + TO + 2);
        end
    endtask

    task automatic test_max_len();
        int c4, c6, c;
        bus.tready = 1'b1;
        q.delete();
        strobe(8'h01, c);
        strobe(8'h02, c);
        strobe(8'h03, c);
        strobe(8'h04, c4);
        strobe(8'h05, c);
        strobe(8'h06, c6);
        wait_beats(6, TO + 20);
        for (int i = 0; i < 6; i++) begin
            logic [9:0] e;
            e = {8'(i + 1), (i == 3 || i == 5), 1'b0};
            checks++;
            if (i >= q.size()) begin
                errors++; $display("FAIL maxlen_beat%0d missing got %0d beats want 6", i, q.size());
            end else if ({q[i].d, q[i].last, q[i].user} !== e) begin
                errors++; $display("FAIL maxlen_beat%0d got %h/%b/%b want %h/%b/0", i, q[i].d, q[i].last, q[i].user, e[9:2], e[1]);
            end
        end
        checks++;
        if (q.size() < 4 || q[3].cyc != 32'(c4 + 2)) begin
            errors++; $display("FAIL maxlen_latency got cycle %0d want %0d", (q.size() < 4) ? -1 : int'(q[3].cyc), c4 + 2);
        end
        checks++;
        if (q.size() < 6 || q[5].cyc != 32'(c6 + TO + 2)) begin
            errors++; $display("FAIL maxlen_tail_latency got cycle %0d want %0d", (q.size() < 6) ? -1 : int'(q[5].cyc), c6 + TO + 2);
        end
    endtask

    task automatic test_overflow();
        int o0, c;
        bus.tready = 1'b0;
        q.delete();
        o0 = ovf_cnt;
        strobe(8'h11, c);
        strobe(8'h12, c);
        strobe(8'h13, c);
        repeat (4) tick();
        checks++;
        if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - o0); end
        bus.tready = 1'b1;
        wait_beats(2, TO + 20);
        checks++;
        if (q.size() < 1 || {q[0].d, q[0].last, q[0].user} !== {8'h11, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ovf_beat0 got %h/%b/%b want 11/0/0", (q.size() < 1) ? 8'hxx : q[0].d, (q.size() < 1) ? 1'bx : q[0].last, (q.size() < 1) ? 1'bx : q[0].user);
        end
        checks++;
        if (q.size() < 2 || {q[1].d, q[1].last, q[1].user} !== {8'h12, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_beat1 got %h/%b/%b want 12/1/1", (q.size() < 2) ? 8'hxx : q[1].d, (q.size() < 2) ? 1'bx : q[1].last, (q.size() < 2) ? 1'bx : q[1].user);
        end
        repeat (2) tick();
        strobe(8'h14, c);
        wait_beats(3, TO + 20);
        checks++;
        if (q.size() != 3 || {q[2].d, q[2].last, q[2].user} !== {8'h14, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_next_frame got %0d beats last=%h/%b/%b want 3 beats 14/1/0", q.size(), (q.size() < 3) ? 8'hxx : q[2].d, (q.size() < 3) ? 1'bx : q[2].last, (q.size() < 3) ? 1'bx : q[2].user);
        end
    endtask

    task automatic test_race();
        int c;
        bus.tready = 1'b1;
        q.delete();
        strobe(8'h20, c);
        repeat (TO) tick();
        strobe(8'h21, c);
        wait_beats(2, TO + 20);
        checks++;
        if (q.size() < 1 || {q[0].d, q[0].last} !== {8'h20, 1'b0}) begin
            errors++; $display("FAIL race_first got %h/%b want 20/0", (q.size() < 1) ? 8'hxx : q[0].d, (q.size() < 1) ? 1'bx : q[0].last);
        end
        checks++;
        if (q.size() < 2 || {q[1].d, q[1].last, q[1].user} !== {8'h21, 1'b1, 1'b0}) begin
            errors++; $display("FAIL race_second got %h/%b/%b want 21/1/0", (q.size() < 2) ? 8'hxx : q[1].d, (q.size() < 2) ? 1'bx : q[1].last, (q.size() < 2) ? 1'bx : q[1].user);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bus.tready = 1'b0;
        strobe(8'h30, c);
        strobe(8'h31, c);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got tvalid=%b busy=%b want 0/0", bus.tvalid, busy);
        end
        bus.tready = 1'b1;
        q.delete();
        strobe(8'h55, c);
        wait_beats(1, TO + 20);
        repeat (5) tick();
        checks++;
        if (q.size() != 1 || {q[0].d, q[0].last, q[0].user} !== {8'h55, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rstmid_frame got %0d beats first=%h/%b/%b want 1 beat 55/1/0", q.size(), (q.size() < 1) ? 8'hxx : q[0].d, (q.size() < 1) ? 1'bx : q[0].last, (q.size() < 1) ? 1'bx : q[0].user);
        end
    endtask

    // Reference: a byte ends its frame when it is the ML-th of the frame, when
    // no further strobe arrives within TO+1 cycles, or when it is the final byte.
    task automatic test_random();
        localparam int K = 40;
        logic [7:0] dat [K];
        int         gap [K];
        logic [9:0] exp [K];
        int pos = 0;
        int c;
        for (int i = 0; i < K; i++) begin
            int sel = $urandom_range(0, 6);
            dat[i] = 8'($urandom_range(0, 255));
            if (sel <= 3)      gap[i] = $urandom_range(1, 3);
            else if (sel == 4) gap[i] = TO + 1;
            else if (sel == 5) gap[i] = TO + 2;
            else               gap[i] = $urandom_range(4, TO);
        end
        for (int i = 0; i < K; i++) begin
            logic last;
            pos++;
            last   = (pos == ML) || (i == K - 1) || (gap[i] > TO + 1);
            exp[i] = {dat[i], last, 1'b0};
            if (last) pos = 0;
        end
        bus.tready = 1'b1;
        q.delete();
        for (int i = 0; i < K; i++) begin
            strobe(dat[i], c);
            if (i != K - 1) repeat (gap[i] - 1) tick();
        end
        wait_beats(K, TO + 20);
        repeat (4) tick();
        checks++;
        if (q.size() != K) begin errors++; $display("FAIL rand_count got %0d beats want %0d", q.size(), K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (i >= q.size()) begin
                errors++; $display("FAIL rand_beat%0d missing", i);
            end else if ({q[i].d, q[i].last, q[i].user} !== exp[i]) begin
                errors++; $display("FAIL rand_beat%0d got %h/%b/%b want %h/%b/%b", i, q[i].d, q[i].last, q[i].user, exp[i][9:2], exp[i][1], exp[i][0]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        bus.tready = 1'b1;
        test_reset();
        test_timeout();
        test_max_len();
        test_overflow();
        test_race();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
